scan_sequencer_16: RTL and testbench

- Synchronous address sequencer that drives a 4-line to 16-line inverted-output decoder: its A output feeds the decoder select, and its Enable_bar feeds one of the decoder's active-low enables (the other is tied low).
- Steps through every decoder output in turn, holding each one active for a programmable dwell.
- Inserts break-before-make blanking so that A never changes while the decoder is enabled; a selected output therefore never glitches to a neighbour.
- Typical uses are scanned displays, keypad rows and time-slot demultiplexing.

---
 rtl/scan_sequencer_16.sv | 130 +++++++++++++
 tb/tb_scan_sequencer_16.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer_16.sv
// scan_sequencer_16
//   Address sequencer for a 4-to-16 inverted-output decoder. It steps the
//   decoder select through every output in turn. Each output is held enabled
//   for DWELL cycles. One blanking cycle before and after each enable keeps
//   A from changing while the decoder is enabled.
//
// Ports
//   Clk        : clock, rising edge
//   Clear      : synchronous active-high reset, priority over everything
//   Run        : level, start or continue scanning
//   Load       : load start address from D (honoured only in IDLE)
//   Single     : 1 = stop after the pass ending at address WIDTH_OUT-1
//   D          : start address
//   A          : decoder select
//   Enable_bar : decoder enable, active low (low only in ACTIVE)
//   Busy       : high in every state except IDLE
//   Wrap       : one-cycle pulse in the BLANK after address WIDTH_OUT-1
module scan_sequencer_16 #(
  parameter int WIDTH_OUT  = 16,
  parameter int DWELL      = 3,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0,
  localparam int WIDTH_IN  = $clog2(WIDTH_OUT)
) (
  input  logic                Clk,
  input  logic                Clear,
  input  logic                Run,
  input  logic                Load,
  input  logic                Single,
  input  logic [WIDTH_IN-1:0] D,
  output logic [WIDTH_IN-1:0] A,
  output logic                Enable_bar,
  output logic                Busy,
  output logic                Wrap
);

  // A counter of one bit is still needed when DWELL is 1.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]    DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [WIDTH_IN-1:0] ADDR_LAST  = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACTIVE,
    BLANK
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH_IN-1:0] a_q, a_d;
  logic [CNT_W-1:0]    dwell_q, dwell_d;
  logic                en_bar_q, en_bar_d;
  logic                busy_q, busy_d;
  logic                wrap_q, wrap_d;

  // The outputs are computed one cycle ahead, so every output is a flop.
  // A moves only on an IDLE load or at the end of BLANK. This leaves a
  // disabled cycle on each side of every enable window.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    dwell_d  = dwell_q;
    en_bar_d = en_bar_q;
    busy_d   = busy_q;
    wrap_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Load) begin
          a_d = D;
        end
        if (Run) begin
          state_d = SETTLE;
          busy_d  = 1'b1;
        end
      end
      SETTLE: begin
        state_d  = ACTIVE;
        dwell_d  = '0;
        en_bar_d = 1'b0;
      end
      ACTIVE: begin
        if (dwell_q == DWELL_LAST) begin
          state_d  = BLANK;
          en_bar_d = 1'b1;
          wrap_d   = (a_q == ADDR_LAST);
        end else begin
          dwell_d = dwell_q + CNT_W'(1);
        end
      end
      BLANK: begin
        // The address advances even when stopping. A resume then carries on
        // at the next output.
        a_d = a_q + WIDTH_IN'(1);
        if (!Run || (Single && (a_q == ADDR_LAST))) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = SETTLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      state_q  <= IDLE;
      a_q      <= '0;
      dwell_q  <= '0;
      en_bar_q <= 1'b1;
      busy_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      dwell_q  <= dwell_d;
      en_bar_q <= en_bar_d;
      busy_q   <= busy_d;
      wrap_q   <= wrap_d;
    end
  end

  assign #(DELAY_RISE, DELAY_FALL) A          = a_q;
  assign #(DELAY_RISE, DELAY_FALL) Enable_bar = en_bar_q;
  assign #(DELAY_RISE, DELAY_FALL) Busy       = busy_q;
  assign #(DELAY_RISE, DELAY_FALL) Wrap       = wrap_q;

endmodule

// File: tb/tb_scan_sequencer_16.sv
// tb_scan_sequencer_16
//   Self-checking bench for scan_sequencer_16 with default parameters.
//   Each table row applies inputs before a rising edge. The row lists the
//   outputs expected just after that edge. A downstream 16-output inverted
//   decoder is modelled so that the one-hot-low output pattern can be checked.
module tb_scan_sequencer_16;

  logic       Clk;
  logic       Clear;
  logic       Run;
  logic       Load;
  logic       Single;
  logic [3:0] D;
  logic [3:0] A;
  logic       Enable_bar;
  logic       Busy;
  logic       Wrap;
  logic [15:0] y;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       clear;
    logic       run;
    logic       load;
    logic       single;
    logic [3:0] d;
    logic [3:0] exp_a;
    logic       exp_enb;
    logic       exp_busy;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[$];

  scan_sequencer_16 dut (
    .Clk        (Clk),
    .Clear      (Clear),
    .Run        (Run),
    .Load       (Load),
    .Single     (Single),
    .D          (D),
    .A          (A),
    .Enable_bar (Enable_bar),
    .Busy       (Busy),
    .Wrap       (Wrap)
  );

  // The downstream decoder has all outputs high while disabled and a single
  // low output when enabled.
  always_comb begin
    y = 16'hFFFF;
    if (!Enable_bar) begin
      y = ~(16'h0001 << A);
    end
  end

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic addVec(input logic c, input logic r, input logic l,
                        input logic s, input logic [3:0] d,
                        input logic [3:0] a, input logic enb,
                        input logic busy, input logic wrap);
    vec_t v;
    v.clear = c; v.run = r; v.load = l; v.single = s; v.d = d;
    v.exp_a = a; v.exp_enb = enb; v.exp_busy = busy; v.exp_wrap = wrap;
    vecs.push_back(v);
  endtask

  // Adds n rows with identical inputs and identical expected outputs.
  task automatic addRep(input int n, input logic c, input logic r,
                        input logic l, input logic s, input logic [3:0] d,
                        input logic [3:0] a, input logic enb,
                        input logic busy, input logic wrap);
    for (int i = 0; i < n; i++) begin
      addVec(c, r, l, s, d, a, enb, busy, wrap);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    Clear  = v.clear;
    Run    = v.run;
    Load   = v.load;
    Single = v.single;
    D      = v.d;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input int row, input vec_t v);
    logic [15:0] exp_y;
    exp_y = v.exp_enb ? 16'hFFFF : ~(16'h0001 << v.exp_a);
    checks++;
    if (A !== v.exp_a) begin
      errors++;
      $display("[TB] FAIL row %0d A: got %h want %h", row, A, v.exp_a);
    end
    checks++;
    if (Enable_bar !== v.exp_enb) begin
      errors++;
      $display("[TB] FAIL row %0d Enable_bar: got %b want %b", row, Enable_bar, v.exp_enb);
    end
    checks++;
    if (Busy !== v.exp_busy) begin
      errors++;
      $display("[TB] FAIL row %0d Busy: got %b want %b", row, Busy, v.exp_busy);
    end
    checks++;
    if (Wrap !== v.exp_wrap) begin
      errors++;
      $display("[TB] FAIL row %0d Wrap: got %b want %b", row, Wrap, v.exp_wrap);
    end
    checks++;
    if (y !== exp_y) begin
      errors++;
      $display("[TB] FAIL row %0d decoder Y: got %h want %h", row, y, exp_y);
    end
  endtask

  // In a continuous scan from E, Wrap must be a single-cycle pulse and
  // successive pulses 80 cycles apart. A must never move while the decoder
  // is enabled, or on the edges where it becomes enabled or disabled.
  task automatic runWrapPeriod();
    int         n;
    logic [3:0] prev_a;
    logic       prev_enb;
    Clear = 1'b0; Load = 1'b1; D = 4'hE; Run = 1'b1; Single = 1'b0;
    @(posedge Clk);
    #1;
    Load = 1'b0;
    n = 0;
    while (Wrap !== 1'b1 && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
    end
    checks++;
    if (Wrap !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_wrap: got timeout after %0d cycles want pulse", n);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (Wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_width: got %b want 0", Wrap);
    end
    n = 1;
    prev_a = A;
    prev_enb = Enable_bar;
    while (Wrap !== 1'b1 && n < 200) begin
      @(posedge Clk);
      #1;
      n++;
      checks++;
      if ((Enable_bar == 1'b0 || prev_enb == 1'b0) && A !== prev_a) begin
        errors++;
        $display("[TB] FAIL a_stable: got A %h (was %h) enb %b want unchanged", A, prev_a, Enable_bar);
      end
      prev_a = A;
      prev_enb = Enable_bar;
    end
    checks++;
    if (n != 80) begin
      errors++;
      $display("[TB] FAIL wrap_period: got %0d want 80", n);
    end
  endtask

  initial begin
    Clear = 1'b1; Run = 1'b0; Load = 1'b0; Single = 1'b0; D = 4'h0;

    // Reset: Clear wins even with Run and Load asserted.
    addRep(2, 1, 1, 1, 0, 4'hA, 4'h0, 1, 0, 0);

    // Start from 0: SETTLE, 3 ACTIVE, BLANK, SETTLE at A=1, ACTIVE.
    addVec(0, 1, 0, 0, 4'h0, 4'h0, 1, 1, 0);
    addRep(3, 0, 1, 0, 0, 4'h0, 4'h0, 0, 1, 0);
    addVec(0, 1, 0, 0, 4'h0, 4'h0, 1, 1, 0);
    addVec(0, 1, 0, 0, 4'h0, 4'h1, 1, 1, 0);
    addRep(3, 0, 1, 0, 0, 4'h0, 4'h1, 0, 1, 0);
    addVec(0, 1, 0, 0, 4'h0, 4'h1, 1, 1, 0);
    addVec(1, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0);

    // Full pass with wrap from E: E, F (Wrap in its BLANK), 0, 1.
    addVec(0, 0, 1, 0, 4'hE, 4'hE, 1, 0, 0);
    addVec(0, 1, 0, 0, 4'h0, 4'hE, 1, 1, 0);
    addRep(3, 0, 1, 0, 0, 4'h0, 4'hE, 0, 1, 0);
    addVec(0, 1, 0, 0, 4'h0, 4'hE, 1, 1, 0);
    addVec(0, 1, 0, 0, 4'h0, 4'hF, 1, 1, 0);
    addRep(3, 0, 1, 0, 0, 4'h0, 4'hF, 0, 1, 0);
    addVec(0, 1, 0, 0, 4'h0, 4'hF, 1, 1, 1);
    addVec(0, 1, 0, 0, 4'h0, 4'h0, 1, 1, 0);
    addRep(3, 0, 1, 0, 0, 4'h0, 4'h0, 0, 1, 0);
    addVec(0, 1, 0, 0, 4'h0, 4'h0, 1, 1, 0);
    addVec(0, 1, 0, 0, 4'h0, 4'h1, 1, 1, 0);
    addVec(0, 1, 0, 0, 4'h0, 4'h1, 0, 1, 0);
    addVec(1, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0);

    // Single pass with Load and Run together at D: D, E, F, then IDLE at 0.
    addVec(0, 1, 1, 1, 4'hD, 4'hD, 1, 1, 0);
    addRep(3, 0, 1, 0, 1, 4'h0, 4'hD, 0, 1, 0);
    addVec(0, 1, 0, 1, 4'h0, 4'hD, 1, 1, 0);
    addVec(0, 1, 0, 1, 4'h0, 4'hE, 1, 1, 0);
    addRep(3, 0, 1, 0, 1, 4'h0, 4'hE, 0, 1, 0);
    addVec(0, 1, 0, 1, 4'h0, 4'hE, 1, 1, 0);
    addVec(0, 1, 0, 1, 4'h0, 4'hF, 1, 1, 0);
    addRep(3, 0, 1, 0, 1, 4'h0, 4'hF, 0, 1, 0);
    addVec(0, 1, 0, 1, 4'h0, 4'hF, 1, 1, 1);
    addVec(0, 1, 0, 1, 4'h0, 4'h0, 1, 0, 0);
    addVec(0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0);

    // Stop and resume: Run drops during ACTIVE at 5, and the dwell still
    // completes. Scanning resumes at 6.
    addVec(0, 0, 1, 0, 4'h5, 4'h5, 1, 0, 0);
    addVec(0, 1, 0, 0, 4'h0, 4'h5, 1, 1, 0);
    addVec(0, 1, 0, 0, 4'h0, 4'h5, 0, 1, 0);
    addRep(2, 0, 0, 0, 0, 4'h0, 4'h5, 0, 1, 0);
    addVec(0, 0, 0, 0, 4'h0, 4'h5, 1, 1, 0);
    addVec(0, 0, 0, 0, 4'h0, 4'h6, 1, 0, 0);
    addVec(0, 0, 0, 0, 4'h0, 4'h6, 1, 0, 0);
    addVec(0, 1, 0, 0, 4'h0, 4'h6, 1, 1, 0);
    addVec(0, 1, 0, 0, 4'h0, 4'h6, 0, 1, 0);

    // Load during ACTIVE at 9 is ignored, then Clear mid-ACTIVE.
    addVec(1, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0);
    addVec(0, 1, 1, 0, 4'h9, 4'h9, 1, 1, 0);
    addRep(2, 0, 1, 1, 0, 4'h3, 4'h9, 0, 1, 0);
    addVec(1, 1, 0, 0, 4'h0, 4'h0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    runWrapPeriod();

    Clear = 1'b1; Run = 1'b0;
    @(posedge Clk);
    #1;
    checks++;
    if (Busy !== 1'b0 || Enable_bar !== 1'b1 || A !== 4'h0) begin
      errors++;
      $display("[TB] FAIL final_clear: got A %h enb %b busy %b want 0 1 0", A, Enable_bar, Busy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
